md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: rs  in  32  operand A, or source value for mthi/mtlo.
REQ-004 SHALL have port: rt  in  32  operand B.
REQ-005 SHALL have port: md_op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 reserved (treated as none).
REQ-006 SHALL have port: md_valid  in  1  the E-stage instruction carrying md_op is valid this cycle.
REQ-007 SHALL have port: md_busy  out  1  registered; high while a mult/div is in progress.
REQ-008 SHALL have port: md_stall  out  1  combinational; tells the pipeline to hold the issuing instruction.
REQ-009 SHALL have port: md_out  out  32  combinational; HI for mfhi, LO for mflo, otherwise 0.

Function
REQ-010 SHALL hold registers HI[31:0], LO[31:0], a cycle counter, a state bit (IDLE/BUSY) and pending result registers.
REQ-011 SHALL define an issue as md_valid=1, md_op in 1..8 and md_stall=0.
REQ-012 SHALL drive md_stall = md_valid & (md_op in 1..8) & md_busy.
REQ-013 SHALL ignore an instruction while it is stalled: no state change and no restart.
REQ-014 SHALL, on issue of op 1-4 in IDLE, capture the computed result into the pending registers, go to BUSY and load the counter: 5 for mult/multu, 10 for div/divu.
REQ-015 SHALL assert md_busy from the cycle after issue for exactly 5 cycles (mult) or 10 cycles (div), decrementing the counter once per cycle.
REQ-016 SHALL, on the clock edge that ends the last busy cycle, write the pending results to HI/LO and return to IDLE with md_busy=0.
REQ-017 SHALL compute mult as {HI,LO} = signed 64-bit product of rs and rt, and multu as the unsigned product.
REQ-018 SHALL compute div as LO = signed quotient truncated toward zero and HI = remainder carrying the sign of rs; divu SHALL produce the unsigned quotient and remainder.
REQ-019 SHALL, for div or divu with rt=0, still run the full 10 busy cycles and then leave HI and LO unchanged.
REQ-020 SHALL, for div with rs=0x80000000 and rt=0xFFFFFFFF, produce LO=0x80000000 and HI=0.
REQ-021 SHALL, on issue of mthi/mtlo, write rs to HI/LO at the next edge with no busy period.
REQ-022 SHALL drive md_out from the current registered HI/LO; an mfhi issued in the same cycle as an mthi write SHALL return the old value.
REQ-023 SHALL keep HI and LO stable during BUSY, so mfhi/mflo always observe fully committed values.
REQ-024 SHALL permit a new mult/div to issue in the cycle after md_busy falls.

Reset
REQ-025 SHALL, when reset=1 at an edge, clear HI, LO, the counter and the pending registers, and force IDLE with md_busy=0.
REQ-026 SHALL give reset priority over issue and completion; an operation in flight SHALL be discarded with no HI/LO write.
REQ-027 SHALL drive md_stall=0 and md_out=0 in the cycle after reset when md_valid=0.

Verification
REQ-028 Bench SHALL cover: mult rs=0xFFFFFFFE, rt=3 -> md_busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 Bench SHALL cover: div rs=-7, rt=2 -> 10 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu rs=7, rt=2 -> LO=3, HI=1.
REQ-030 Bench SHALL cover: mflo held with md_valid=1 during busy -> md_stall=1 every busy cycle, then md_stall=0 with md_out equal to the new LO on the first cycle after completion.
REQ-031 Bench SHALL cover: mthi rs=0x12345678 followed by mfhi -> md_out=0x12345678 with no stall; a second mult issued while busy is ignored and results match the first operation only.
REQ-032 Bench SHALL cover: reset asserted on the 3rd cycle of a div -> next cycle md_busy=0, HI=LO=0, and no later write occurs.
REQ-033 Bench SHALL cover: divu with rt=0 after HI=1 and LO=2 are loaded -> 10 busy cycles, then HI=1 and LO=2 unchanged.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : multi-cycle multiply/divide unit with HI/LO registers
// Rev 1.0
// ============================================================================
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [3:0]  md_op,
  input  logic        md_valid,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] md_out
);

  localparam logic [3:0] C_OP_MULT  = 4'd1;
  localparam logic [3:0] C_OP_MULTU = 4'd2;
  localparam logic [3:0] C_OP_DIV   = 4'd3;
  localparam logic [3:0] C_OP_DIVU  = 4'd4;
  localparam logic [3:0] C_OP_MTHI  = 4'd5;
  localparam logic [3:0] C_OP_MTLO  = 4'd6;
  localparam logic [3:0] C_OP_MFHI  = 4'd7;
  localparam logic [3:0] C_OP_MFLO  = 4'd8;

  localparam logic [3:0] C_MULT_CYCLES = 4'd5;
  localparam logic [3:0] C_DIV_CYCLES  = 4'd10;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;

  logic        w_op_known;
  logic        w_issue;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_sden;
  logic [31:0] w_uden;
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [31:0] w_squot;
  logic [31:0] w_srem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_op_known = (md_op >= C_OP_MULT) && (md_op <= C_OP_MFLO);
  assign md_busy    = (r_state == BUSY);
  assign md_stall   = md_valid & w_op_known & md_busy;
  assign w_issue    = md_valid & w_op_known & ~md_stall;

  // Overflow case divides by 1 instead, which yields exactly LO=rs, HI=0.
  assign w_div_zero = (rt == 32'd0);
  assign w_div_ovf  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
  assign w_sden     = (w_div_zero || w_div_ovf) ? 32'd1 : rt;
  assign w_uden     = w_div_zero ? 32'd1 : rt;

  assign w_sprod = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign w_uprod = {32'd0, rs} * {32'd0, rt};
  assign w_squot = $signed(rs) / $signed(w_sden);
  assign w_srem  = $signed(rs) % $signed(w_sden);

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (md_op)
      C_OP_MULT:  begin w_res_hi = w_sprod[63:32]; w_res_lo = w_sprod[31:0]; end
      C_OP_MULTU: begin w_res_hi = w_uprod[63:32]; w_res_lo = w_uprod[31:0]; end
      C_OP_DIV:   begin w_res_hi = w_srem;         w_res_lo = w_squot;       end
      C_OP_DIVU:  begin w_res_hi = rs % w_uden;    w_res_lo = rs / w_uden;   end
      default:    begin w_res_hi = 32'd0;          w_res_lo = 32'd0;         end
    endcase
  end

  always_comb begin
    md_out = 32'd0;
    if (md_op == C_OP_MFHI)      md_out = r_hi;
    else if (md_op == C_OP_MFLO) md_out = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_we <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            case (md_op)
              C_OP_MULT, C_OP_MULTU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_we <= 1'b1;
                r_cnt     <= C_MULT_CYCLES;
                r_state   <= BUSY;
              end
              C_OP_DIV, C_OP_DIVU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_we <= ~w_div_zero;
                r_cnt     <= C_DIV_CYCLES;
                r_state   <= BUSY;
              end
              C_OP_MTHI: r_hi <= rs;
              C_OP_MTLO: r_lo <= rs;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (r_cnt == 4'd1) begin
            if (r_pend_we) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= 4'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
